seg_display_scanner: RTL

Consumer side of the CPU's syscall display path. Whenever the CPU executes a display syscall it writes a 32-bit value, and this block latches that value. It then drives it as eight hexadecimal digits on a time-multiplexed, active-low 7-segment display. The block also latches the CPU halt flag and shows it on the decimal point of digit 0. It sits at the board top level, beside the CPU core.

---
 rtl/seg_display_scanner.sv | 82 ++++++++
 1 files changed

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 8-digit hex display driver for the CPU display syscall.
// Latches the displayed word and the halt flag, scans one digit per DIV cycles.
module seg_display_scanner #(
  parameter int DIV   = 4,
  parameter bit BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_we,
  input  logic [31:0] disp_data,
  input  logic        halt,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [2:0]    dig;
  logic [31:0]   shown;
  logic          halted;

  logic [3:0]    nib;
  logic [31:0]   upper;
  logic          blank_dig;
  logic [6:0]    seg_lo;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Leading-zero test looks at the selected nibble and everything above it.
  always_comb begin
    nib       = shown[{dig, 2'b00} +: 4];
    upper     = shown >> {dig, 2'b00};
    blank_dig = BLANK && (dig != 3'd0) && (upper == 32'd0);
    seg_lo    = blank_dig ? 7'h7F : hex_to_seg(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dig     <= 3'd0;
      shown   <= 32'd0;
      halted  <= 1'b0;
      an      <= 8'hFF;
      seg     <= 8'hFF;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        dig     <= dig + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (disp_we) shown <= disp_data;
      if (halt) halted <= 1'b1;
      an  <= ~(8'b1 << dig);
      seg <= {~((dig == 3'd0) && halted), seg_lo};
    end
  end

endmodule
